// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared states, tap constant, seeds and LFSR/MISR step functions for the multiplier BIST
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_CMP,
        S_DONE
    } bist_state_t;

    // Taps at bits 15, 13, 12, 10, shared by the pattern generator and the MISR
    localparam logic [15:0] TAPS          = 16'hB400;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & TAPS)};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [15:0] d);
        return {m[14:0], ^(m & TAPS)} ^ d;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - 16-bit multiple-input signature register with synchronous load and enable
module bist_misr
    import bist_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_MISR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [15:0] i_data,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/bist_ctrl.sv
// rtl/bist_ctrl.sv - BIST sequencer: LFSR operands into the multiplier, MISR compaction, golden compare
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter int          N_PAT      = 256,
    parameter int          MULT_LAT   = 0,
    parameter logic [15:0] LFSR_SEED  = DEF_LFSR_SEED,
    parameter logic [15:0] MISR_SEED  = DEF_MISR_SEED,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     func_a,
    input  logic [WIDTH-1:0]     func_b,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_p,
    output logic [2*WIDTH-1:0]   tp,
    output logic [2*WIDTH-1:0]   sig,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    generate
        if (WIDTH != 8) begin : g_chk_width
            $error("bist_ctrl: taps are fixed for a 16-bit LFSR/MISR, WIDTH must be 8");
        end
        if (N_PAT < 1 || N_PAT > 65535) begin : g_chk_npat
            $error("bist_ctrl: N_PAT must be in 1..65535");
        end
        if (MULT_LAT < 0 || MULT_LAT > 2) begin : g_chk_lat
            $error("bist_ctrl: MULT_LAT must be in 0..2");
        end
        if (LFSR_SEED == 16'h0000) begin : g_chk_seed
            $error("bist_ctrl: LFSR_SEED must be nonzero");
        end
    endgenerate

    bist_state_t        r_state;
    logic [2*WIDTH-1:0] r_lfsr;
    logic [15:0]        r_pat_cnt;
    logic [1:0]         r_drn;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               w_run;
    logic               w_vld;
    logic               w_misr_load;
    logic               w_misr_en;
    logic [2*WIDTH-1:0] w_sig;

    assign w_run       = (r_state == S_RUN);
    assign w_misr_load = (r_state == S_SEED);
    assign w_misr_en   = w_vld & ~abort;

    // Valid bit tracks each issued pattern through the multiplier pipeline
    generate
        if (MULT_LAT == 0) begin : g_vld_comb
            assign w_vld = w_run;
        end else begin : g_vld_pipe
            logic [MULT_LAT-1:0] r_vpipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else if (w_misr_load || abort) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= (r_vpipe << 1) | MULT_LAT'(w_run);
                end
            end
            assign w_vld = r_vpipe[MULT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_pat_cnt <= '0;
            r_drn     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else if (abort && r_busy) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SEED;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_SEED: begin
                    r_lfsr    <= LFSR_SEED;
                    r_pat_cnt <= '0;
                    r_pass    <= 1'b0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    r_lfsr    <= lfsr_next(r_lfsr);
                    r_pat_cnt <= r_pat_cnt + 16'd1;
                    r_drn     <= '0;
                    if (r_pat_cnt == 16'(N_PAT - 1)) begin
                        r_state <= (MULT_LAT == 0) ? S_CMP : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_drn <= r_drn + 2'd1;
                    if (r_drn == 2'(MULT_LAT - 1)) begin
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_pass  <= (w_sig == GOLDEN_SIG);
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Functional traffic passes through whenever no test is in flight
    always_comb begin
        mult_a = '0;
        mult_b = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                mult_a = func_a;
                mult_b = func_b;
            end
            S_RUN: begin
                mult_a = r_lfsr[2*WIDTH-1:WIDTH];
                mult_b = r_lfsr[WIDTH-1:0];
            end
            default: ;
        endcase
    end

    bist_misr #(
        .SEED (MISR_SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_misr_load),
        .i_en   (w_misr_en),
        .i_data (mult_p),
        .o_sig  (w_sig)
    );

    assign tp   = r_lfsr;
    assign sig  = w_sig;
    assign busy = r_busy;
    assign done = r_done;
    assign pass = r_pass;

endmodule

// File: tb/tb_bist_ctrl.sv
// tb/tb_bist_ctrl.sv - directed bench: exact, stuck-at and pipelined multiplier variants of bist_ctrl
module tb_bist_ctrl;

    function automatic logic [15:0] model_sig(input int n, input bit stuck3);
        logic [15:0] q;
        logic [15:0] m;
        logic [15:0] p;
        q = 16'hACE1;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            p = 16'(q[15:8]) * 16'(q[7:0]);
            if (stuck3) p[3] = 1'b0;
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ p;
            q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
        return m;
    endfunction

    function automatic logic [15:0] model_lfsr(input int n);
        logic [15:0] q;
        q = 16'hACE1;
        for (int i = 0; i < n; i++) q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        return q;
    endfunction

    localparam logic [15:0] GOLD = model_sig(256, 1'b0);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  func_a;
    logic [7:0]  func_b;
    logic [7:0]  ma [3];
    logic [7:0]  mb [3];
    logic [15:0] mp [3];
    logic [15:0] tp [3];
    logic [15:0] sg [3];
    logic        bsy [3];
    logic        dn [3];
    logic        ps [3];
    logic [15:0] r_p2a;
    logic [15:0] r_p2b;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    // 0: exact combinational, 1: product bit 3 stuck at 0, 2: two-stage registered
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bist_ctrl #(
            .WIDTH      (8),
            .N_PAT      (256),
            .MULT_LAT   ((g == 2) ? 2 : 0),
            .LFSR_SEED  (16'hACE1),
            .MISR_SEED  (16'h0000),
            .GOLDEN_SIG (GOLD)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start),
            .abort  (abort),
            .func_a (func_a),
            .func_b (func_b),
            .mult_a (ma[g]),
            .mult_b (mb[g]),
            .mult_p (mp[g]),
            .tp     (tp[g]),
            .sig    (sg[g]),
            .busy   (bsy[g]),
            .done   (dn[g]),
            .pass   (ps[g])
        );
    end

    assign mp[0] = 16'(ma[0]) * 16'(mb[0]);
    assign mp[1] = (16'(ma[1]) * 16'(mb[1])) & 16'hFFF7;
    assign mp[2] = r_p2b;

    always_ff @(posedge clk) begin
        r_p2a <= 16'(ma[2]) * 16'(mb[2]);
        r_p2b <= r_p2a;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_full(input bit pulse);
        int c [3];
        for (int k = 0; k < 3; k++) c[k] = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) chk($sformatf("seed_busy%0d", k), 16'(bsy[k]), 16'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("run1_a%0d", k), 16'(ma[k]), 16'h00AC);
            chk($sformatf("run1_b%0d", k), 16'(mb[k]), 16'h00E1);
            chk($sformatf("run1_tp%0d", k), tp[k], 16'hACE1);
        end
        @(posedge clk); #1;
        chk("run2_a", 16'(ma[0]), 16'h0059);
        chk("run2_b", 16'(mb[0]), 16'h00C3);
        for (int n = 3; n <= 400 && (c[0] == 0 || c[1] == 0 || c[2] == 0); n++) begin
            if (pulse && (n == 10 || n == 200)) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k < 3; k++) if (c[k] == 0 && dn[k]) c[k] = n + 1;
        end
        chk("done_cyc0", 16'(c[0]), 16'd259);
        chk("done_cyc1", 16'(c[1]), 16'd259);
        chk("done_cyc2", 16'(c[2]), 16'd261);
        chk("sig0", sg[0], GOLD);
        chk("sig1", sg[1], model_sig(256, 1'b1));
        chk("sig2", sg[2], GOLD);
        chk("pass0", 16'(ps[0]), 16'd1);
        chk("pass1", 16'(ps[1]), 16'd0);
        chk("pass2", 16'(ps[2]), 16'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        func_a = 8'h3C;
        func_b = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy%0d", k), 16'(bsy[k]), 16'd0);
            chk($sformatf("rst_done%0d", k), 16'(dn[k]), 16'd0);
            chk($sformatf("rst_pass%0d", k), 16'(ps[k]), 16'd0);
            chk($sformatf("rst_tp%0d", k), tp[k], 16'hACE1);
            chk($sformatf("rst_sig%0d", k), sg[k], 16'h0000);
            chk($sformatf("rst_a%0d", k), 16'(ma[k]), 16'h003C);
            chk($sformatf("rst_b%0d", k), 16'(mb[k]), 16'h005A);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_full(1'b0);

        func_a = 8'h96;
        func_b = 8'h0F;
        repeat (3) @(posedge clk);
        #1;
        chk("done_mux_a", 16'(ma[0]), 16'h0096);
        chk("done_mux_b", 16'(mb[0]), 16'h000F);
        chk("done_hold_sig", sg[0], GOLD);
        chk("done_hold_pass", 16'(ps[0]), 16'd1);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("run100_tp", tp[0], model_lfsr(99));
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 16'(bsy[0]), 16'd0);
        chk("abort_done", 16'(dn[0]), 16'd0);
        chk("abort_pass", 16'(ps[0]), 16'd0);
        chk("abort_a", 16'(ma[0]), 16'h0096);
        chk("abort_b", 16'(mb[0]), 16'h000F);
        chk("abort_a2", 16'(ma[2]), 16'h0096);
        @(posedge clk); #1;
        chk("abort_stay_idle", 16'(bsy[0]), 16'd0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arst_busy%0d", k), 16'(bsy[k]), 16'd0);
            chk($sformatf("arst_done%0d", k), 16'(dn[k]), 16'd0);
            chk($sformatf("arst_pass%0d", k), 16'(ps[k]), 16'd0);
            chk($sformatf("arst_tp%0d", k), tp[k], 16'hACE1);
            chk($sformatf("arst_sig%0d", k), sg[k], 16'h0000);
            chk($sformatf("arst_a%0d", k), 16'(ma[k]), 16'h0096);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_full(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
